// File: rtl/inner_prod_accum.sv
// Accumulates LENGTH signed products into a wide accumulator and hands off one
// saturated WIDTH-bit inner product per vector over a valid/ready output port.
module inner_prod_accum #(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and a raised out_valid holds its payload
    // until the transfer. clear overrides both handshakes.

    localparam int CNT_W = $clog2(LENGTH);
    // Guard bits let a whole vector of extreme products sum without wrapping.
    localparam int ACC_W = WIDTH + CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum_full;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_accept;
    logic             pos_ovf;
    logic             neg_ovf;
    logic [WIDTH-1:0] sat_data;
    logic             sat_flag;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (count == LAST_CNT);

    assign in_ext   = {{CNT_W{in_data[WIDTH-1]}}, in_data};
    assign sum_full = acc + in_ext;

    // The sum fits in WIDTH bits only when every guard bit matches the sign.
    assign pos_ovf = !sum_full[ACC_W-1] && (|sum_full[ACC_W-2:WIDTH-1]);
    assign neg_ovf = sum_full[ACC_W-1] && !(&sum_full[ACC_W-2:WIDTH-1]);

    always_comb begin
        sat_data = sum_full[WIDTH-1:0];
        sat_flag = 1'b0;
        if (pos_ovf) begin
            sat_data = MAX_VAL;
            sat_flag = 1'b1;
        end else if (neg_ovf) begin
            sat_data = MIN_VAL;
            sat_flag = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (last_accept) state_next = OUTPUT;
                OUTPUT:  if (out_ready)   state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state == ACCUM) && !clear && rst_n;
        out_valid = (state == OUTPUT);
    end

    // The accumulator and count are zeroed as the final product is captured,
    // so the block is already primed for the next vector when OUTPUT hands off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (last_accept) begin
            acc      <= '0;
            count    <= '0;
            out_data <= sat_data;
            out_sat  <= sat_flag;
        end else if (accept) begin
            acc   <= sum_full;
            count <= count + 1'b1;
        end
    end

endmodule

// File: doc/inner_prod_accum.md
INNER_PROD_ACCUM -- requirements
Module: inner_prod_accum

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: bit width of the signed fixed-point product samples and of the result.
REQ-002 SHALL provide parameter LENGTH, default 8: number of products summed per inner product; legal range is 2..1024.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port clear  input  1  synchronous abort that discards any partial or pending result.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid product.
REQ-007 SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  signed product from the upstream multiplier stage; same fixed-point format as out_data.
REQ-009 SHALL have port out_valid  output  1  out_data and out_sat hold a finished inner product.
REQ-010 SHALL have port out_ready  input  1  the downstream stage accepts the result.
REQ-011 SHALL have port out_data  output  WIDTH  signed, saturated inner-product result.
REQ-012 SHALL have port out_sat  output  1  out_data was clipped to a WIDTH limit.

Function
REQ-013 SHALL implement two states: ACCUM (collecting products) and OUTPUT (holding a result).
REQ-014 SHALL drive in_ready = (state==ACCUM) && !clear && rst_n.
- A product is accepted on a rising edge where in_valid && in_ready.
REQ-015 SHALL keep an internal signed accumulator of WIDTH+clog2(LENGTH) bits.
- Each accepted in_data is sign-extended and added.
- The accumulator SHALL NOT wrap and SHALL NOT saturate mid-vector.
REQ-016 SHALL keep a count of 0..LENGTH-1; it increments on each accept.
REQ-017 On accepting the LENGTH-th product of a vector, the block SHALL:
- register the full sum (accumulator + that product);
- move to OUTPUT;
- assert out_valid on the next cycle (latency 1 cycle after the last accept).
REQ-018 Result rule:
- If the full sum exceeds 2^(WIDTH-1)-1, out_data SHALL be 2^(WIDTH-1)-1 and out_sat SHALL be 1.
- If the full sum is below -2^(WIDTH-1), out_data SHALL be -2^(WIDTH-1) and out_sat SHALL be 1.
- Otherwise out_data SHALL be the sum and out_sat SHALL be 0.
REQ-019 In OUTPUT, out_valid, out_data and out_sat SHALL hold stable until out_valid && out_ready.
REQ-020 On the OUTPUT handshake, the block SHALL:
- return to ACCUM;
- zero the accumulator and count;
- deassert out_valid on the next cycle.
REQ-021 out_data and out_sat SHALL keep their last value while out_valid is 0.
REQ-022 Gaps in in_valid SHALL NOT change the accumulator or count.
REQ-023 Minimum period per vector SHALL be LENGTH+1 cycles; no overlap of the next vector with OUTPUT.
REQ-024 clear=1 at a rising edge SHALL:
- return the block to ACCUM;
- zero the accumulator and count;
- deassert out_valid and drop any pending result;
- not accept the in_data presented in that cycle.
REQ-025 rst_n has priority over clear; clear has priority over both handshakes.

Reset
REQ-026 With rst_n low at a rising edge, the block SHALL set state=ACCUM, accumulator=0, count=0, out_valid=0, out_data=0, out_sat=0.
REQ-027 in_ready SHALL be 0 while rst_n is low and SHALL be 1 on the first cycle after rst_n is sampled high.
REQ-028 Reset asserted mid-vector or in OUTPUT SHALL discard all state; the first post-reset accept SHALL start a new vector.

Verification (WIDTH=16, LENGTH=4)
REQ-029 Basic sum:
- Stimulus: 1,2,3,4 back-to-back, out_ready=1.
- Response: out_valid one cycle after the 4th accept; out_data=10, out_sat=0.
REQ-030 Saturation:
- Stimulus: four products of 0x7FFF.
- Response: out_data=0x7FFF, out_sat=1.
- Stimulus: four products of 0x8000.
- Response: out_data=0x8000, out_sat=1.
REQ-031 Intermediate overflow cancels:
- Stimulus: 0x7FFF, 0x7FFF, 0x8000, 0x8000.
- Response: out_data=0xFFFE (-2), out_sat=0.
REQ-032 Backpressure:
- Stimulus: out_ready=0 for 5 cycles while in_valid=1 with the next vector's data.
- Response: out_data stable and in_ready=0 throughout; the first product of the next vector is accepted the cycle after the handshake.
REQ-033 Gaps and clear:
- Stimulus: 7,7 accepted, then clear, then 5,_,5,5,_,5 (bubbles).
- Response: out_data=20.
- Stimulus: clear during OUTPUT.
- Response: out_valid=0 on the next cycle, and that result is never handed off.
REQ-034 Reset mid-vector:
- Stimulus: rst_n low for 1 cycle after 2 accepts, then 1,1,1,1.
- Response: out_data=4.
